xgmii_rx_axis_64: RTL and testbench

//  Receive-side XGMII decoder. Takes the 64-bit XGMII RX word stream from a 10G PCS/PMA
//  (156.25 MHz core clock) and emits frames as AXI-Stream. Strips preamble/SFD and flags

---
 rtl/xgmii_rx_axis_64_if.sv | 12 +
 rtl/xgmii_rx_axis_64.sv | 278 +++++++++++++++++++++++++++
 tb/tb_xgmii_rx_axis_64.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xgmii_rx_axis_64_if.sv
// AXI-Stream frame bus carried out of the XGMII receive decoder.
// No tready: the consumer must accept every beat.
interface xgmii_rx_axis_64_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/xgmii_rx_axis_64.sv
// XGMII 64-bit receive decoder: strips preamble/SFD, emits frames as AXI-Stream,
// flags aborted/oversized frames and keeps saturating frame/error counters.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | between frames, waiting for a start word on lane 0
//  PAYLOAD | inside a frame, words flow through the 1-word hold register
//  DROP    | frame exceeded MAX_FRAME_LEN, discarding until terminate/error
//
// A frame can end with one more beat than the hold register can supply
// (partial terminate word, or the oversize word itself). That beat is parked
// in a pending register and always goes out on the following cycle; the
// state has already left PAYLOAD by then, so it never collides with a held
// word. A start word with a bad SFD that arrives mid-frame only aborts the
// current frame; it does not add a separate framing pulse.
module xgmii_rx_axis_64 #(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            xgmii_rxd,
  input  logic [7:0]             xgmii_rxc,
  xgmii_rx_axis_64_if.master     m_axis,
  output logic                   stat_rx_frame,
  output logic                   stat_rx_err_bad_frame,
  output logic                   stat_rx_err_framing,
  output logic [COUNT_WIDTH-1:0] rx_frame_count,
  output logic [COUNT_WIDTH-1:0] rx_err_count
);

  localparam logic [7:0]  CH_START   = 8'hFB;
  localparam logic [7:0]  CH_TERM    = 8'hFD;
  localparam logic [7:0]  CH_ERROR   = 8'hFE;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam int          LEN_W      = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] WORD_BYTES = LEN_W'(8);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t state_q, state_n;

  logic [2:0]  low_lane;
  logic [7:0]  low_byte;
  logic        any_ctl, has_fe, is_start, start_ok, start_bad, is_term;
  logic [7:0]  term_keep;
  logic [63:0] term_data;

  logic             hold_valid_q, hold_valid_n;
  logic [63:0]      hold_data_q, hold_data_n;
  logic             pend_valid_q, pend_valid_n;
  logic [63:0]      pend_data_q, pend_data_n;
  logic [7:0]       pend_keep_q, pend_keep_n;
  logic             pend_user_q, pend_user_n;
  logic [LEN_W-1:0] rem_q, rem_n;

  logic        out_valid_q, out_valid_n;
  logic [63:0] out_data_q, out_data_n;
  logic [7:0]  out_keep_q, out_keep_n;
  logic        out_last_q, out_last_n;
  logic        out_user_q, out_user_n;
  logic        frame_q, frame_n;
  logic        bad_q, bad_n;
  logic        framing_q, framing_n;

  logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_n;
  logic [COUNT_WIDTH-1:0] err_cnt_q, err_cnt_n;
  logic [1:0]             err_inc;
  logic [COUNT_WIDTH:0]   err_sum;

  // Decode the incoming word: lowest control lane, FE anywhere, start/terminate.
  always_comb begin
    low_lane  = 3'd0;
    has_fe    = 1'b0;
    term_data = 64'd0;
    for (int i = 7; i >= 0; i--) begin
      if (xgmii_rxc[i]) low_lane = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == CH_ERROR)) has_fe = 1'b1;
    end
    any_ctl   = |xgmii_rxc;
    low_byte  = xgmii_rxd[{low_lane, 3'b000} +: 8];
    is_start  = xgmii_rxc[0] && (xgmii_rxd[7:0] == CH_START);
    start_ok  = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);
    start_bad = is_start && !start_ok;
    is_term   = any_ctl && !has_fe && (low_byte == CH_TERM);
    term_keep = ~(8'hFF << low_lane);
    for (int i = 0; i < 8; i++) begin
      if (term_keep[i]) term_data[8*i +: 8] = xgmii_rxd[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        if (!any_ctl) begin
          if (rem_q < WORD_BYTES) state_n = DROP;
        end else if (is_term) begin
          state_n = IDLE;
        end else begin
          state_n = start_ok ? PAYLOAD : IDLE;
        end
      end
      DROP: begin
        if (start_ok)     state_n = PAYLOAD;
        else if (any_ctl) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Beat generation, hold/pending bookkeeping, length budget and statistics.
  always_comb begin
    hold_valid_n = hold_valid_q;
    hold_data_n  = hold_data_q;
    pend_valid_n = 1'b0;
    pend_data_n  = 64'd0;
    pend_keep_n  = 8'd0;
    pend_user_n  = 1'b0;
    rem_n        = rem_q;
    out_valid_n  = 1'b0;
    out_data_n   = 64'd0;
    out_keep_n   = 8'd0;
    out_last_n   = 1'b0;
    out_user_n   = 1'b0;
    framing_n    = 1'b0;

    if (pend_valid_q) begin
      out_valid_n = 1'b1;
      out_data_n  = pend_data_q;
      out_keep_n  = pend_keep_q;
      out_last_n  = 1'b1;
      out_user_n  = pend_user_q;
    end

    unique case (state_q)
      IDLE, DROP: begin
        if (start_ok) begin
          hold_valid_n = 1'b0;
          rem_n        = LEN_MAX;
        end else if (start_bad) begin
          framing_n = 1'b1;
        end
      end
      PAYLOAD: begin
        if (!any_ctl) begin
          if (hold_valid_q) begin
            out_valid_n = 1'b1;
            out_data_n  = hold_data_q;
            out_keep_n  = 8'hFF;
          end
          if (rem_q < WORD_BYTES) begin
            hold_valid_n = 1'b0;
            pend_valid_n = 1'b1;
            pend_data_n  = xgmii_rxd;
            pend_keep_n  = 8'hFF;
            pend_user_n  = 1'b1;
          end else begin
            hold_valid_n = 1'b1;
            hold_data_n  = xgmii_rxd;
            rem_n        = rem_q - WORD_BYTES;
          end
        end else if (is_term) begin
          hold_valid_n = 1'b0;
          if (low_lane == 3'd0) begin
            if (hold_valid_q) begin
              out_valid_n = 1'b1;
              out_data_n  = hold_data_q;
              out_keep_n  = 8'hFF;
              out_last_n  = 1'b1;
            end else begin
              framing_n = 1'b1;
            end
          end else begin
            if (hold_valid_q) begin
              out_valid_n = 1'b1;
              out_data_n  = hold_data_q;
              out_keep_n  = 8'hFF;
            end
            pend_valid_n = 1'b1;
            pend_data_n  = term_data;
            pend_keep_n  = term_keep;
            pend_user_n  = (LEN_W'(low_lane) > rem_q);
          end
        end else begin
          hold_valid_n = 1'b0;
          if (hold_valid_q) begin
            out_valid_n = 1'b1;
            out_data_n  = hold_data_q;
            out_keep_n  = 8'hFF;
            out_last_n  = 1'b1;
            out_user_n  = 1'b1;
          end else begin
            framing_n = 1'b1;
          end
          if (start_ok) rem_n = LEN_MAX;
        end
      end
      default: ;
    endcase

    frame_n = out_valid_n && out_last_n && !out_user_n;
    bad_n   = out_valid_n && out_last_n && out_user_n;

    frame_cnt_n = frame_cnt_q;
    if (frame_n && !(&frame_cnt_q)) frame_cnt_n = frame_cnt_q + COUNT_WIDTH'(1);

    err_inc   = {1'b0, bad_n} + {1'b0, framing_n};
    err_sum   = {1'b0, err_cnt_q} + (COUNT_WIDTH+1)'(err_inc);
    err_cnt_n = err_sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : err_sum[COUNT_WIDTH-1:0];
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 64'd0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 64'd0;
      pend_keep_q  <= 8'd0;
      pend_user_q  <= 1'b0;
      rem_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 64'd0;
      out_keep_q   <= 8'd0;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      frame_q      <= 1'b0;
      bad_q        <= 1'b0;
      framing_q    <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_n;
      hold_data_q  <= hold_data_n;
      pend_valid_q <= pend_valid_n;
      pend_data_q  <= pend_data_n;
      pend_keep_q  <= pend_keep_n;
      pend_user_q  <= pend_user_n;
      rem_q        <= rem_n;
      out_valid_q  <= out_valid_n;
      out_data_q   <= out_data_n;
      out_keep_q   <= out_keep_n;
      out_last_q   <= out_last_n;
      out_user_q   <= out_user_n;
      frame_q      <= frame_n;
      bad_q        <= bad_n;
      framing_q    <= framing_n;
      frame_cnt_q  <= frame_cnt_n;
      err_cnt_q    <= err_cnt_n;
    end
  end

  assign m_axis.tdata           = out_data_q;
  assign m_axis.tkeep           = out_keep_q;
  assign m_axis.tvalid          = out_valid_q;
  assign m_axis.tlast           = out_last_q;
  assign m_axis.tuser           = out_user_q;
  assign stat_rx_frame          = frame_q;
  assign stat_rx_err_bad_frame  = bad_q;
  assign stat_rx_err_framing    = framing_q;
  assign rx_frame_count         = frame_cnt_q;
  assign rx_err_count           = err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_axis_64.sv
// Directed bench for the XGMII receive decoder: a per-cycle vector table for
// the short frame cases, plus hand sequences for oversize and mid-frame reset.
module tb_xgmii_rx_axis_64;

  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] BADSF_W = 64'hD4555555555555FB;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;

  logic        clk;
  logic        rst;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        stat_rx_frame, stat_rx_err_bad_frame, stat_rx_err_framing;
  logic [31:0] rx_frame_count, rx_err_count;

  xgmii_rx_axis_64_if axis_if ();

  xgmii_rx_axis_64 #(.MAX_FRAME_LEN(1518), .COUNT_WIDTH(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .xgmii_rxd             (xgmii_rxd),
    .xgmii_rxc             (xgmii_rxc),
    .m_axis                (axis_if),
    .stat_rx_frame         (stat_rx_frame),
    .stat_rx_err_bad_frame (stat_rx_err_bad_frame),
    .stat_rx_err_framing   (stat_rx_err_framing),
    .rx_frame_count        (rx_frame_count),
    .rx_err_count          (rx_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  rxc;
    logic [63:0] rxd;
    logic        v;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    logic        sf;
    logic        sb;
    logic        sfr;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   nbeats;
  int   extra_last;
  int   stray;
  logic [76:0] cap190;

  function automatic logic [63:0] dw(int n);
    return {8{8'(n)}} ^ 64'h0123456789ABCDEF;
  endfunction

  function automatic logic [7:0] kmask(int k);
    logic [7:0] m;
    m = 8'hFF;
    return ~(m << k);
  endfunction

  function automatic logic [63:0] bmask(logic [7:0] km);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 8; i++) if (km[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] term_c(int k);
    logic [7:0] m;
    m = 8'hFF;
    return m << k;
  endfunction

  function automatic logic [63:0] term_d(int k, logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = (i < k) ? d[8*i +: 8] : ((i == k) ? 8'hFD : 8'h07);
    return r;
  endfunction

  function automatic logic [63:0] errw(int n);
    logic [63:0] r;
    r = dw(n);
    r[31:24] = 8'hFE;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic [63:0] d, input logic v,
                     input logic [63:0] ed, input logic [7:0] ek, input logic el,
                     input logic eu, input logic sfr);
    vec_t r;
    r.rxc = c; r.rxd = d; r.v = v; r.d = ed; r.k = ek; r.l = el; r.u = eu;
    r.sf  = v & el & ~eu;
    r.sb  = v & el & eu;
    r.sfr = sfr;
    tbl.push_back(r);
  endtask

  task automatic quiet(input logic [7:0] c, input logic [63:0] d);
    add(c, d, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frm(input logic [7:0] c, input logic [63:0] d);
    add(c, d, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic beat(input logic [7:0] c, input logic [63:0] d, input logic [63:0] ed,
                      input logic [7:0] ek, input logic el, input logic eu);
    add(c, d, 1'b1, ed, ek, el, eu, 1'b0);
  endtask

  task automatic cyc(input logic [7:0] c, input logic [63:0] d);
    xgmii_rxc = c;
    xgmii_rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    if (axis_if.tvalid) begin
      nbeats++;
      if (nbeats == 190)
        cap190 = {axis_if.tvalid, axis_if.tkeep, axis_if.tlast, axis_if.tuser,
                  stat_rx_err_bad_frame, stat_rx_frame, axis_if.tdata};
      else if (axis_if.tlast)
        extra_last++;
    end
  endtask

  function automatic logic [127:0] all_out();
    return {axis_if.tvalid, axis_if.tlast, axis_if.tuser, axis_if.tkeep, axis_if.tdata,
            stat_rx_frame, stat_rx_err_bad_frame, stat_rx_err_framing,
            rx_frame_count != 0, rx_err_count != 0};
  endfunction

  initial begin
    rst = 1'b1;
    xgmii_rxc = 8'hFF;
    xgmii_rxd = IDLE_W;

    // Single-frame cases, one record per input cycle.
    quiet(8'h01, START_W);
    quiet(8'h00, dw(1));
    for (int n = 2; n <= 8; n++) beat(8'h00, dw(n), dw(n-1), 8'hFF, 1'b0, 1'b0);
    beat(term_c(0), term_d(0, 64'd0), dw(8), 8'hFF, 1'b1, 1'b0);
    quiet(8'hFF, IDLE_W);

    quiet(8'h01, START_W);
    quiet(8'h00, dw(1));
    for (int n = 2; n <= 7; n++) beat(8'h00, dw(n), dw(n-1), 8'hFF, 1'b0, 1'b0);
    beat(term_c(4), term_d(4, dw(8)), dw(7), 8'hFF, 1'b0, 1'b0);
    beat(8'hFF, IDLE_W, dw(8) & bmask(kmask(4)), 8'h0F, 1'b1, 1'b0);

    quiet(8'h01, START_W);
    quiet(8'h00, dw(1));
    beat(8'h00, dw(2), dw(1), 8'hFF, 1'b0, 1'b0);
    beat(8'h08, errw(3), dw(2), 8'hFF, 1'b1, 1'b1);
    quiet(8'hFF, IDLE_W);

    quiet(8'h01, START_W);
    quiet(8'h00, dw(1));
    beat(8'h00, dw(2), dw(1), 8'hFF, 1'b0, 1'b0);
    beat(term_c(1), term_d(1, dw(3)), dw(2), 8'hFF, 1'b0, 1'b0);
    beat(8'h01, START_W, dw(3) & bmask(kmask(1)), 8'h01, 1'b1, 1'b0);
    quiet(8'h00, dw(1));
    beat(8'h00, dw(2), dw(1), 8'hFF, 1'b0, 1'b0);
    beat(term_c(0), term_d(0, 64'd0), dw(2), 8'hFF, 1'b1, 1'b0);
    quiet(8'hFF, IDLE_W);

    frm(8'h01, BADSF_W);
    quiet(8'h00, dw(1));
    quiet(8'h00, dw(2));
    quiet(8'hFF, IDLE_W);

    quiet(8'h01, START_W);
    frm(term_c(0), term_d(0, 64'd0));
    quiet(8'h01, START_W);
    frm(8'h08, errw(5));
    quiet(8'hFF, IDLE_W);

    quiet(8'h01, START_W);
    quiet(8'h00, dw(1));
    beat(8'h00, dw(2), dw(1), 8'hFF, 1'b0, 1'b0);
    beat(8'h01, START_W, dw(2), 8'hFF, 1'b1, 1'b1);
    quiet(8'h00, dw(4));
    beat(term_c(0), term_d(0, 64'd0), dw(4), 8'hFF, 1'b1, 1'b0);
    quiet(8'hFF, IDLE_W);

    quiet(8'h01, START_W);
    quiet(term_c(3), term_d(3, dw(6)));
    beat(8'hFF, IDLE_W, dw(6) & bmask(kmask(3)), 8'h07, 1'b1, 1'b0);
    quiet(8'hFF, IDLE_W);

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", all_out(), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rxc, tbl[i].rxd);
      if (tbl[i].v)
        chk($sformatf("v%0d beat", i),
            {axis_if.tvalid, axis_if.tkeep, axis_if.tlast, axis_if.tuser, axis_if.tdata},
            {1'b1, tbl[i].k, tbl[i].l, tbl[i].u, tbl[i].d});
      else
        chk($sformatf("v%0d novalid", i), {127'd0, axis_if.tvalid}, 128'd0);
      chk($sformatf("v%0d stats", i),
          {stat_rx_frame, stat_rx_err_bad_frame, stat_rx_err_framing},
          {tbl[i].sf, tbl[i].sb, tbl[i].sfr});
    end
    chk("table frame count", rx_frame_count, 128'd6);
    chk("table err count", rx_err_count, 128'd5);

    // Oversize: 200 words against a 1518-byte limit.
    nbeats = 0;
    extra_last = 0;
    cap190 = '0;
    cyc(8'h01, START_W);
    observe();
    for (int n = 1; n <= 200; n++) begin
      cyc(8'h00, dw(n));
      observe();
    end
    cyc(term_c(0), term_d(0, 64'd0));
    observe();
    for (int n = 0; n < 3; n++) begin
      cyc(8'hFF, IDLE_W);
      observe();
    end
    chk("oversize beat count", nbeats, 128'd190);
    chk("oversize beat190", cap190, {1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, dw(190)});
    chk("oversize other tlast", extra_last, 128'd0);
    chk("oversize err count", rx_err_count, 128'd6);
    chk("oversize frame count", rx_frame_count, 128'd6);

    // Reset in the middle of a frame.
    cyc(8'h01, START_W);
    cyc(8'h00, dw(1));
    cyc(8'h00, dw(2));
    cyc(8'h00, dw(3));
    rst = 1'b1;
    cyc(8'h00, dw(4));
    chk("midreset outputs", all_out(), 128'd0);
    cyc(8'h00, dw(5));
    chk("midreset hold", all_out(), 128'd0);
    rst = 1'b0;
    stray = 0;
    cyc(8'h00, dw(6));
    stray += int'(axis_if.tvalid);
    cyc(8'h00, dw(7));
    stray += int'(axis_if.tvalid);
    cyc(term_c(0), term_d(0, 64'd0));
    stray += int'(axis_if.tvalid);
    for (int n = 0; n < 3; n++) begin
      cyc(8'hFF, IDLE_W);
      stray += int'(axis_if.tvalid);
    end
    chk("post-reset stray beats", stray, 128'd0);
    chk("post-reset counters", {rx_frame_count, rx_err_count}, 128'd0);

    cyc(8'h01, START_W);
    cyc(8'h00, dw(9));
    cyc(term_c(0), term_d(0, 64'd0));
    chk("post-reset frame",
        {axis_if.tvalid, axis_if.tkeep, axis_if.tlast, axis_if.tuser, stat_rx_frame, axis_if.tdata},
        {1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, dw(9)});
    cyc(8'hFF, IDLE_W);
    chk("post-reset frame count", {rx_frame_count, rx_err_count}, {64'd0, 32'd1, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
